// File: rtl/cva6_cfg_info_responder.sv
// Minimal derived core-configuration type plus a read-only responder that
// exposes the elaborated configuration as an 11-word map (random read or full dump).
package config_pkg;
    typedef struct packed {
        int unsigned XLEN;
        int unsigned FLen;
        int unsigned PLEN;
        int unsigned VLEN;
        bit          RVA;
        bit          RVB;
        bit          RVC;
        bit          RVD;
        bit          RVF;
        bit          RVH;
        bit          RVS;
        bit          RVU;
        bit          RVV;
        bit          RVZCB;
        bit          RVZCMP;
        bit          RVZCMT;
        bit          RVZiCond;
        bit          RVZicntr;
        bit          RVZihpm;
        bit          ZKN;
        bit          XF16;
        bit          XF16ALT;
        bit          XF8;
        bit          XFVec;
        bit          CvxifEn;
        bit          SuperscalarEn;
        bit          MmuPresent;
        bit          DebugEn;
        int unsigned NrCommitPorts;
        int unsigned NrIssuePorts;
        int unsigned NrWbPorts;
        int unsigned NrRgprPorts;
        int unsigned NR_SB_ENTRIES;
        int unsigned NrLoadBufEntries;
        int unsigned ICACHE_SET_ASSOC;
        int unsigned ICACHE_INDEX_WIDTH;
        int unsigned ICACHE_LINE_WIDTH;
        int unsigned DCACHE_SET_ASSOC;
        int unsigned DCACHE_INDEX_WIDTH;
        int unsigned DCACHE_LINE_WIDTH;
        int unsigned InstrTlbEntries;
        int unsigned DataTlbEntries;
        int unsigned SharedTlbDepth;
        int unsigned NrPMPEntries;
        int unsigned RASDepth;
        int unsigned BTBEntries;
        int unsigned BHTEntries;
        logic [63:0] DmBaseAddress;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '0;
endpackage

module cva6_cfg_info_responder #(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
    parameter int unsigned NrWords = 11
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [7:0]  req_addr_i,
    input  logic        dump_start_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_data_o,
    output logic        rsp_err_o,
    output logic        rsp_last_o,
    output logic        busy_o
);
    localparam int unsigned AddrW = 8;
    localparam int unsigned DataW = 32;
    localparam int unsigned IdxW  = 4;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NrWords - 1);

    if (NrWords != 11) begin : gen_nr_words_check
        $error("cva6_cfg_info_responder: NrWords must be 11");
    end

    // Constant map words, built from the configuration at elaboration.
    localparam logic [DataW-1:0] W0 = 32'hC5A6_0001;
    localparam logic [DataW-1:0] W1 = {8'(CVA6Cfg.VLEN), 8'(CVA6Cfg.PLEN),
                                       8'(CVA6Cfg.FLen), 8'(CVA6Cfg.XLEN)};
    localparam logic [DataW-1:0] W2 = {8'h00,
        CVA6Cfg.DebugEn, CVA6Cfg.MmuPresent, CVA6Cfg.SuperscalarEn, CVA6Cfg.CvxifEn,
        CVA6Cfg.XFVec, CVA6Cfg.XF8, CVA6Cfg.XF16ALT, CVA6Cfg.XF16,
        CVA6Cfg.ZKN, CVA6Cfg.RVZihpm, CVA6Cfg.RVZicntr, CVA6Cfg.RVZiCond,
        CVA6Cfg.RVZCMT, CVA6Cfg.RVZCMP, CVA6Cfg.RVZCB, CVA6Cfg.RVV,
        CVA6Cfg.RVU, CVA6Cfg.RVS, CVA6Cfg.RVH, CVA6Cfg.RVF,
        CVA6Cfg.RVD, CVA6Cfg.RVC, CVA6Cfg.RVB, CVA6Cfg.RVA};
    localparam logic [DataW-1:0] W3 = {8'(CVA6Cfg.NrLoadBufEntries), 8'(CVA6Cfg.NR_SB_ENTRIES),
                                       4'(CVA6Cfg.NrRgprPorts), 4'(CVA6Cfg.NrWbPorts),
                                       4'(CVA6Cfg.NrIssuePorts), 4'(CVA6Cfg.NrCommitPorts)};
    localparam logic [DataW-1:0] W4 = {16'(CVA6Cfg.ICACHE_LINE_WIDTH),
                                       8'(CVA6Cfg.ICACHE_INDEX_WIDTH), 8'(CVA6Cfg.ICACHE_SET_ASSOC)};
    localparam logic [DataW-1:0] W5 = {16'(CVA6Cfg.DCACHE_LINE_WIDTH),
                                       8'(CVA6Cfg.DCACHE_INDEX_WIDTH), 8'(CVA6Cfg.DCACHE_SET_ASSOC)};
    localparam logic [DataW-1:0] W6 = {8'(CVA6Cfg.NrPMPEntries), 8'(CVA6Cfg.SharedTlbDepth),
                                       8'(CVA6Cfg.DataTlbEntries), 8'(CVA6Cfg.InstrTlbEntries)};
    localparam logic [DataW-1:0] W7 = {16'(CVA6Cfg.BHTEntries), 8'(CVA6Cfg.BTBEntries),
                                       8'(CVA6Cfg.RASDepth)};
    localparam logic [DataW-1:0] W8 = CVA6Cfg.DmBaseAddress[31:0];
    localparam logic [DataW-1:0] W9 = CVA6Cfg.DmBaseAddress[63:32];
    localparam logic [DataW-1:0] W10 = W0 ^ W1 ^ W2 ^ W3 ^ W4 ^ W5 ^ W6 ^ W7 ^ W8 ^ W9;

    function automatic logic [DataW-1:0] word_f(input logic [IdxW-1:0] idx);
        case (idx)
            4'd0:    word_f = W0;
            4'd1:    word_f = W1;
            4'd2:    word_f = W2;
            4'd3:    word_f = W3;
            4'd4:    word_f = W4;
            4'd5:    word_f = W5;
            4'd6:    word_f = W6;
            4'd7:    word_f = W7;
            4'd8:    word_f = W8;
            4'd9:    word_f = W9;
            4'd10:   word_f = W10;
            default: word_f = '0;
        endcase
    endfunction

    typedef enum logic [1:0] {StIdle, StResp, StDump} state_e;

    state_e           state_q, state_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic             valid_q, valid_d;
    logic [DataW-1:0] data_q, data_d;
    logic             err_q, err_d;
    logic             last_q, last_d;
    logic             busy_q, busy_d;

    logic             rd_err;
    logic [DataW-1:0] rd_data;
    logic [IdxW-1:0]  idx_nxt;
    logic             req_ready_c;

    // Random-access lookup; out-of-range addresses read as zero with an error flag.
    assign rd_err  = (req_addr_i >= AddrW'(NrWords));
    assign rd_data = rd_err ? '0 : word_f(req_addr_i[IdxW-1:0]);
    assign idx_nxt = idx_q + IdxW'(1);

    always_comb begin : p_next
        state_d     = state_q;
        idx_d       = idx_q;
        valid_d     = valid_q;
        data_d      = data_q;
        err_d       = err_q;
        last_d      = last_q;
        busy_d      = busy_q;
        req_ready_c = 1'b0;
        case (state_q)
            StIdle: begin
                req_ready_c = !dump_start_i;
                if (dump_start_i) begin
                    state_d = StDump;
                    idx_d   = '0;
                    valid_d = 1'b1;
                    data_d  = W0;
                    err_d   = 1'b0;
                    last_d  = 1'b0;
                    busy_d  = 1'b1;
                end else if (req_valid_i) begin
                    state_d = StResp;
                    valid_d = 1'b1;
                    data_d  = rd_data;
                    err_d   = rd_err;
                    last_d  = 1'b0;
                end
            end
            StResp: begin
                req_ready_c = rsp_ready_i;
                if (rsp_ready_i) begin
                    if (req_valid_i) begin
                        data_d = rd_data;
                        err_d  = rd_err;
                    end else begin
                        state_d = StIdle;
                        valid_d = 1'b0;
                        data_d  = '0;
                        err_d   = 1'b0;
                    end
                end
            end
            StDump: begin
                if (rsp_ready_i) begin
                    if (idx_q == LastIdx) begin
                        state_d = StIdle;
                        idx_d   = '0;
                        valid_d = 1'b0;
                        data_d  = '0;
                        last_d  = 1'b0;
                        busy_d  = 1'b0;
                    end else begin
                        idx_d  = idx_nxt;
                        data_d = word_f(idx_nxt);
                        last_d = (idx_nxt == LastIdx);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin : p_regs
        if (rst_i) begin
            state_q <= StIdle;
            idx_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            err_q   <= err_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
        end
    end

    // Ready depends on the live handshake, so it cannot be registered; held low in reset.
    assign req_ready_o = req_ready_c && !rst_i;
    assign rsp_valid_o = valid_q;
    assign rsp_data_o  = data_q;
    assign rsp_err_o   = err_q;
    assign rsp_last_o  = last_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_cva6_cfg_info_responder.sv
// Self-checking bench: fixed read vectors, randomized reads against a queue model,
// and dump sequences with backpressure, mid-dump reset and restart.
module tb_cva6_cfg_info_responder;
    localparam int unsigned NrWords = 11;

    function automatic config_pkg::cva6_cfg_t make_cfg();
        config_pkg::cva6_cfg_t c;
        c = '0;
        c.XLEN = 64; c.FLen = 64; c.PLEN = 56; c.VLEN = 64;
        c.RVA = 1'b1; c.RVC = 1'b1; c.RVD = 1'b1; c.RVF = 1'b1; c.RVS = 1'b1; c.RVU = 1'b1;
        c.NrCommitPorts = 18; c.NrIssuePorts = 1; c.NrWbPorts = 4; c.NrRgprPorts = 2;
        c.NR_SB_ENTRIES = 8; c.NrLoadBufEntries = 2;
        c.ICACHE_SET_ASSOC = 4; c.ICACHE_INDEX_WIDTH = 12; c.ICACHE_LINE_WIDTH = 128;
        c.DCACHE_SET_ASSOC = 8; c.DCACHE_INDEX_WIDTH = 12; c.DCACHE_LINE_WIDTH = 128;
        c.InstrTlbEntries = 16; c.DataTlbEntries = 16; c.SharedTlbDepth = 64; c.NrPMPEntries = 8;
        c.RASDepth = 2; c.BTBEntries = 32; c.BHTEntries = 128;
        c.DmBaseAddress = 64'h1234_5678_0000_0800;
        return c;
    endfunction

    localparam config_pkg::cva6_cfg_t Cfg = make_cfg();

    logic        clk, rst;
    logic        req_valid, req_ready, dump_start;
    logic [7:0]  req_addr;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_last, busy;
    logic [31:0] rsp_data;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_map [NrWords];

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        logic        err;
    } vec_t;
    vec_t vecs [14];

    cva6_cfg_info_responder #(.CVA6Cfg(Cfg), .NrWords(NrWords)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_addr_i  (req_addr),
        .dump_start_i(dump_start),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_data_o  (rsp_data),
        .rsp_err_o   (rsp_err),
        .rsp_last_o  (rsp_last),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: each field reduced modulo its width and placed by arithmetic weight.
    function automatic longint unsigned fld(input longint unsigned v, input int bits);
        return v % (64'd1 << bits);
    endfunction

    function automatic logic [31:0] model_word(input int idx);
        bit ext [24];
        longint unsigned w;
        ext = '{Cfg.RVA, Cfg.RVB, Cfg.RVC, Cfg.RVD, Cfg.RVF, Cfg.RVH, Cfg.RVS, Cfg.RVU,
                Cfg.RVV, Cfg.RVZCB, Cfg.RVZCMP, Cfg.RVZCMT, Cfg.RVZiCond, Cfg.RVZicntr,
                Cfg.RVZihpm, Cfg.ZKN, Cfg.XF16, Cfg.XF16ALT, Cfg.XF8, Cfg.XFVec,
                Cfg.CvxifEn, Cfg.SuperscalarEn, Cfg.MmuPresent, Cfg.DebugEn};
        w = 0;
        case (idx)
            0: w = 64'hC5A6_0001;
            1: w = fld(Cfg.XLEN, 8) + fld(Cfg.FLen, 8) * 256
                 + fld(Cfg.PLEN, 8) * 65536 + fld(Cfg.VLEN, 8) * 16777216;
            2: for (int b = 0; b < 24; b++) if (ext[b]) w += 64'd1 << b;
            3: w = fld(Cfg.NrCommitPorts, 4) + fld(Cfg.NrIssuePorts, 4) * 16
                 + fld(Cfg.NrWbPorts, 4) * 256 + fld(Cfg.NrRgprPorts, 4) * 4096
                 + fld(Cfg.NR_SB_ENTRIES, 8) * 65536 + fld(Cfg.NrLoadBufEntries, 8) * 16777216;
            4: w = fld(Cfg.ICACHE_SET_ASSOC, 8) + fld(Cfg.ICACHE_INDEX_WIDTH, 8) * 256
                 + fld(Cfg.ICACHE_LINE_WIDTH, 16) * 65536;
            5: w = fld(Cfg.DCACHE_SET_ASSOC, 8) + fld(Cfg.DCACHE_INDEX_WIDTH, 8) * 256
                 + fld(Cfg.DCACHE_LINE_WIDTH, 16) * 65536;
            6: w = fld(Cfg.InstrTlbEntries, 8) + fld(Cfg.DataTlbEntries, 8) * 256
                 + fld(Cfg.SharedTlbDepth, 8) * 65536 + fld(Cfg.NrPMPEntries, 8) * 16777216;
            7: w = fld(Cfg.RASDepth, 8) + fld(Cfg.BTBEntries, 8) * 256
                 + fld(Cfg.BHTEntries, 16) * 65536;
            8: w = Cfg.DmBaseAddress % 64'h1_0000_0000;
            9: w = Cfg.DmBaseAddress / 64'h1_0000_0000;
            default: w = 0;
        endcase
        return 32'(w);
    endfunction

    // Full dump; mode 0 random stalls, mode 1 ready tied high (one word per cycle).
    task automatic dump_check(input int mode);
        int k, ncyc;
        bit done, pulsed;
        logic [31:0] x, cur;
        k = 0; ncyc = 0; done = 0; pulsed = 0; x = '0;
        dump_start = 1'b1; req_valid = 1'b1; req_addr = 8'd1;
        #1;
        chk1("dump_start_req_ready", req_ready, 1'b0);
        step();
        dump_start = 1'b0; req_valid = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            chk1($sformatf("dump%0d_valid_w%0d", mode, k), rsp_valid, 1'b1);
            chk32($sformatf("dump%0d_data_w%0d", mode, k), rsp_data, exp_map[k]);
            chk1($sformatf("dump%0d_last_w%0d", mode, k), rsp_last, k == 10);
            chk1($sformatf("dump%0d_busy_w%0d", mode, k), busy, 1'b1);
            chk1($sformatf("dump%0d_err_w%0d", mode, k), rsp_err, 1'b0);
            cur = rsp_data;
            rsp_ready  = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            req_valid  = 1'($urandom_range(0, 1));
            req_addr   = 8'($urandom_range(0, 12));
            dump_start = (k == 4) && !pulsed;
            pulsed     = pulsed | dump_start;
            #1;
            chk1($sformatf("dump%0d_req_ready_w%0d", mode, k), req_ready, 1'b0);
            step();
            ncyc++;
            dump_start = 1'b0;
            if (rsp_ready) begin
                x = x ^ cur;
                if (k == 10) done = 1;
                k++;
            end
        end
        rsp_ready = 1'b0; req_valid = 1'b0;
        chk1($sformatf("dump%0d_completed", mode), done, 1'b1);
        chk1($sformatf("dump%0d_end_valid", mode), rsp_valid, 1'b0);
        chk1($sformatf("dump%0d_end_busy", mode), busy, 1'b0);
        chk32($sformatf("dump%0d_xor", mode), x, 32'h0);
        if (mode == 1) chk32("dump_throughput_cycles", 32'(ncyc), 32'd11);
    endtask

    initial begin
        logic [32:0] q [$];
        logic        exp_ready;

        rst = 1'b1; req_valid = 1'b0; req_addr = '0; dump_start = 1'b0; rsp_ready = 1'b0;

        for (int i = 0; i < 10; i++) exp_map[i] = model_word(i);
        exp_map[10] = '0;
        for (int i = 0; i < 10; i++) exp_map[10] = exp_map[10] ^ exp_map[i];

        vecs[0]  = '{8'd0,   32'hC5A6_0001, 1'b0};
        vecs[1]  = '{8'd1,   32'h4038_4040, 1'b0};
        vecs[2]  = '{8'd2,   32'h0000_00DD, 1'b0};
        vecs[3]  = '{8'd3,   32'h0208_2412, 1'b0};
        vecs[4]  = '{8'd4,   32'h0080_0C04, 1'b0};
        vecs[5]  = '{8'd5,   32'h0080_0C08, 1'b0};
        vecs[6]  = '{8'd6,   32'h0840_1010, 1'b0};
        vecs[7]  = '{8'd7,   32'h0080_2002, 1'b0};
        vecs[8]  = '{8'd11,  32'h0,         1'b1};
        vecs[9]  = '{8'd255, 32'h0,         1'b1};
        vecs[10] = '{8'd8,   32'h0000_0800, 1'b0};
        vecs[11] = '{8'd9,   32'h1234_5678, 1'b0};
        vecs[12] = '{8'd10,  exp_map[10],   1'b0};
        vecs[13] = '{8'd15,  32'h0,         1'b1};

        repeat (2) @(posedge clk);
        #1;
        chk1("reset_rsp_valid", rsp_valid, 1'b0);
        chk32("reset_rsp_data", rsp_data, 32'h0);
        chk1("reset_rsp_err", rsp_err, 1'b0);
        chk1("reset_rsp_last", rsp_last, 1'b0);
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_req_ready", req_ready, 1'b0);
        rst = 1'b0;
        step();

        // Table-driven single reads with a 1-cycle latency check.
        for (int i = 0; i < 14; i++) begin
            req_valid = 1'b1; req_addr = vecs[i].addr;
            #1;
            chk1($sformatf("tbl%0d_req_ready", i), req_ready, 1'b1);
            chk1($sformatf("tbl%0d_pre_valid", i), rsp_valid, 1'b0);
            step();
            req_valid = 1'b0;
            chk1($sformatf("tbl%0d_valid", i), rsp_valid, 1'b1);
            chk32($sformatf("tbl%0d_data_addr%0d", i, vecs[i].addr), rsp_data, vecs[i].data);
            chk1($sformatf("tbl%0d_err", i), rsp_err, vecs[i].err);
            chk1($sformatf("tbl%0d_last", i), rsp_last, 1'b0);
            rsp_ready = 1'b1;
            step();
            rsp_ready = 1'b0;
            chk1($sformatf("tbl%0d_idle_valid", i), rsp_valid, 1'b0);
        end

        // Back-to-back reads of 3 then 4.
        req_valid = 1'b1; req_addr = 8'd3;
        step();
        chk32("b2b_first_data", rsp_data, exp_map[3]);
        req_addr = 8'd4; rsp_ready = 1'b1;
        #1;
        chk1("b2b_req_ready", req_ready, 1'b1);
        step();
        req_valid = 1'b0;
        chk1("b2b_second_valid", rsp_valid, 1'b1);
        chk32("b2b_second_data", rsp_data, exp_map[4]);
        step();
        rsp_ready = 1'b0;
        chk1("b2b_drain_valid", rsp_valid, 1'b0);

        // dump_start while a response is pending must be ignored.
        req_valid = 1'b1; req_addr = 8'd5;
        step();
        req_valid = 1'b0; dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        chk1("resp_dump_ignored_busy", busy, 1'b0);
        chk32("resp_dump_ignored_data", rsp_data, exp_map[5]);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk1("resp_dump_ignored_idle", rsp_valid, 1'b0);

        // Randomized reads against a queue of expected responses.
        for (int c = 0; c < 300; c++) begin
            int r;
            r = int'($urandom_range(0, 3));
            req_valid = 1'($urandom_range(0, 1));
            req_addr  = (r == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
            rsp_ready = 1'($urandom_range(0, 1));
            #1;
            exp_ready = (q.size() == 0) ? 1'b1 : rsp_ready;
            chk1("rand_req_ready", req_ready, exp_ready);
            step();
            if (q.size() != 0 && rsp_ready) void'(q.pop_front());
            if (req_valid && exp_ready) begin
                if (req_addr < 8'(NrWords)) q.push_back({1'b0, exp_map[req_addr]});
                else q.push_back({1'b1, 32'h0});
            end
            chk1("rand_rsp_valid", rsp_valid, q.size() != 0);
            if (q.size() != 0) begin
                chk32("rand_rsp_data", rsp_data, q[0][31:0]);
                chk1("rand_rsp_err", rsp_err, q[0][32]);
            end
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk1("rand_drain_valid", rsp_valid, 1'b0);

        dump_check(0);

        // Stall at W5, then reset asynchronously between clock edges.
        dump_start = 1'b1;
        step();
        dump_start = 1'b0; rsp_ready = 1'b1;
        repeat (5) step();
        rsp_ready = 1'b0;
        step();
        chk32("stall_w5_data", rsp_data, exp_map[5]);
        chk1("stall_w5_busy", busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk1("async_rst_valid", rsp_valid, 1'b0);
        chk1("async_rst_busy", busy, 1'b0);
        chk32("async_rst_data", rsp_data, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();

        dump_check(1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cva6_cfg_info_responder.md
Name: cva6_cfg_info_responder

Overview:
- Read-only responder that exposes the elaborated core configuration as a fixed map of 32-bit words.
- The configuration is a derived config_pkg::cva6_cfg_t. Debug, boot firmware and the verification environment use the map to discover core capabilities at run time.
- Two access modes:
  - Random-access read channel: request/response valid/ready.
  - Sequential dump mode: streams the whole map on the same response channel.
- Sits beside the CSR file; its request port connects to the debug/peripheral interconnect.

Parameters:
- CVA6Cfg, config_pkg::cva6_cfg_empty, derived core configuration that is encoded into the map.
- NrWords, 11, number of map words. Fixed by the map below; any other value is an elaboration error.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- req_valid_i  in  1  read request valid
- req_ready_o  out  1  read request accepted when high together with req_valid_i
- req_addr_i  in  8  word index
- dump_start_i  in  1  one-cycle pulse; starts a full-map dump
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed
- rsp_data_o  out  32  response word
- rsp_err_o  out  1  address out of range (rsp_data_o = 0)
- rsp_last_o  out  1  high on the final dump word (index 10) only
- busy_o  out  1  high while in DUMP state

Behaviour:
Reset and clocking:
- One clock domain. Asynchronous active-high reset.
- Reset values: all outputs 0, state IDLE, dump index 0. rsp_valid_o drops immediately on rst_i assertion, even mid-dump or mid-handshake.

Word map (all fields zero-extended; integer values truncated to field width):
- W0: 0xC5A6_0001 (magic/version).
- W1: XLEN[7:0], FLen[15:8], PLEN[23:16], VLEN[31:24].
- W2: extension bitmap. Bit 0 RVA, 1 RVB, 2 RVC, 3 RVD, 4 RVF, 5 RVH, 6 RVS, 7 RVU, 8 RVV, 9 RVZCB, 10 RVZCMP, 11 RVZCMT, 12 RVZiCond, 13 RVZicntr, 14 RVZihpm, 15 ZKN, 16 XF16, 17 XF16ALT, 18 XF8, 19 XFVec, 20 CvxifEn, 21 SuperscalarEn, 22 MmuPresent, 23 DebugEn. Bits 31:24 are 0.
- W3: NrCommitPorts[3:0], NrIssuePorts[7:4], NrWbPorts[11:8], NrRgprPorts[15:12], NR_SB_ENTRIES[23:16], NrLoadBufEntries[31:24].
- W4: ICACHE_SET_ASSOC[7:0], ICACHE_INDEX_WIDTH[15:8], ICACHE_LINE_WIDTH[31:16].
- W5: DCACHE_SET_ASSOC[7:0], DCACHE_INDEX_WIDTH[15:8], DCACHE_LINE_WIDTH[31:16].
- W6: InstrTlbEntries[7:0], DataTlbEntries[15:8], SharedTlbDepth[23:16], NrPMPEntries[31:24].
- W7: RASDepth[7:0], BTBEntries[15:8], BHTEntries[31:16].
- W8: DmBaseAddress[31:0].
- W9: DmBaseAddress[63:32].
- W10: XOR of W0..W9.
- The map is an elaboration-time constant: no registers hold it.

State machine (IDLE, RESP, DUMP):
- IDLE:
  - req_ready_o = !dump_start_i.
  - Request accepted -> register data/err next edge, rsp_valid_o = 1, go to RESP.
  - dump_start_i -> go to DUMP, index 0, rsp_valid_o = 1 with W0 next edge.
  - Simultaneous dump_start_i and req_valid_i: dump wins; the request is not accepted.
- RESP:
  - req_ready_o = rsp_ready_i (back-to-back reads allowed, one outstanding response).
  - On rsp_ready_i: if a new request is accepted, load it and stay in RESP; else rsp_valid_o = 0 and go to IDLE.
  - dump_start_i is ignored in RESP.
- DUMP:
  - req_ready_o = 0 and busy_o = 1. dump_start_i is ignored.
  - Each word is held stable until rsp_ready_i.
  - On handshake: index + 1, present the next word next cycle.
  - rsp_last_o = 1 with W10. The handshake on W10 -> rsp_valid_o = 0, busy_o = 0, IDLE.
- rsp_data_o, rsp_err_o and rsp_last_o are held stable while rsp_valid_o && !rsp_ready_i.

Latency and error handling:
- Read latency: 1 cycle from accept to rsp_valid_o.
- Sustained throughput: 1 word/cycle with rsp_ready_i tied high.
- req_addr_i >= 11 -> rsp_err_o = 1, rsp_data_o = 0. There is no other side effect.

Test Plan:
- Reset, then read addr 0 -> rsp_valid_o one cycle after accept, rsp_data_o = 0xC5A60001, rsp_err_o = 0.
- 64-bit config (XLEN = 64, FLen = 64, PLEN = 56, VLEN = 64), read addr 1 -> 0x40384040. Read addr 2 on the RV64IMAFDC config -> bitmap has bits 0, 2, 3, 4, 6, 7 set.
- Read addr 11 and addr 255 -> rsp_err_o = 1, rsp_data_o = 0. A following read of addr 8 returns DmBaseAddress[31:0] correctly.
- Pulse dump_start_i with rsp_ready_i randomly stalled -> exactly 11 words W0..W10 in order, each stable under backpressure. rsp_last_o only on W10. The XOR of W0..W10 = 0. req_ready_o = 0 throughout; a second dump_start_i mid-dump is ignored.
- dump_start_i and req_valid_i in the same IDLE cycle -> request not accepted and the dump proceeds. Back-to-back reads of addr 3 then 4 with rsp_ready_i = 1 -> one response per cycle.
- Assert rst_i while stalled mid-dump at W5 -> rsp_valid_o and busy_o go 0 asynchronously. After release, a new dump restarts at W0.
